// File: rtl/sp_pkg.sv
// sp_pkg: shared defaults and derived sizes for the result-matrix scratchpad
// access controller, plus the controller state encoding.
//   SP_NTARGETS : number of addressable result targets
//   DATA_WIDTH  : element width
//   BUS_WIDTH   : bus / scratchpad word width
//   MAX_DIM, NELEM, AW, TW : derived matrix dimension, words per target,
//                            address width and target-select width
package sp_pkg;

  localparam int SP_NTARGETS = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int BUS_WIDTH   = 64;

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NELEM   = MAX_DIM * MAX_DIM;
  localparam int AW      = 2 * $clog2(MAX_DIM);
  localparam int TW      = (SP_NTARGETS > 2) ? $clog2(SP_NTARGETS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    STREAM
  } state_e;

endpackage

// File: rtl/sp_stream_out.sv
// sp_stream_out: valid/ready output register for streaming one whole target.
// Holds the count of words still to be read from the scratchpad and tells the
// parent when to advance the read address.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : one-cycle stream grant, arms NELEM words
//   i_rd_data        : scratchpad read data for the current address
//   i_ready          : consumer ready
//   o_data, o_valid  : streamed word and its valid
//   o_busy           : stream in progress
//   o_done           : one-cycle pulse after the final word is accepted
//   o_load           : a word is captured this cycle (advance address)
//   o_last           : the final word is accepted this cycle
module sp_stream_out #(
  parameter int BUS_WIDTH = 64,
  parameter int NELEM     = 4,
  parameter int CW        = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [BUS_WIDTH-1:0] i_rd_data,
  input  logic                 i_ready,
  output logic [BUS_WIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_load,
  output logic                 o_last
);

  localparam logic [CW-1:0] LOAD_CNT = CW'(NELEM);

  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [CW-1:0]        r_remain;

  // The output register refills whenever it is empty or being drained, so
  // data stays put while valid is held against a low ready.
  assign o_load = r_busy && (!r_valid || i_ready) && (r_remain != '0);
  assign o_last = r_busy && r_valid && i_ready && (r_remain == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_remain <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy   <= 1'b1;
        r_valid  <= 1'b0;
        r_remain <= LOAD_CNT;
      end else if (o_load) begin
        r_data   <= i_rd_data;
        r_valid  <= 1'b1;
        r_remain <= r_remain - 1'b1;
      end else if (o_last) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/sp_access_ctrl.sv
// sp_access_ctrl: shares the result scratchpad's single port between the
// matmul engine write-back burst, a valid/ready stream of one whole target,
// and single-word host reads (fixed priority engine > stream > host).
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   eng_*                        : engine burst request/grant/data/done
//   str_*                        : stream request/target, output word handshake
//   host_rd_*                    : host read request, address, registered data
//   sp_*                         : scratchpad strobe, mode, address, targets, data
//   err_o, err_clr_i             : sticky protocol error flag and its clear
// Optional feature: define SP_CTRL_ERR_EN to enable err_o; otherwise err_o is
// tied low and err_clr_i is ignored.
module sp_access_ctrl #(
  parameter  int SP_NTARGETS = sp_pkg::SP_NTARGETS,
  parameter  int DATA_WIDTH  = sp_pkg::DATA_WIDTH,
  parameter  int BUS_WIDTH   = sp_pkg::BUS_WIDTH,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int NELEM       = MAX_DIM * MAX_DIM,
  localparam int AW          = 2 * $clog2(MAX_DIM),
  localparam int TW          = (SP_NTARGETS > 2) ? $clog2(SP_NTARGETS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 eng_req_i,
  input  logic [TW-1:0]        eng_target_i,
  input  logic                 eng_valid_i,
  input  logic [BUS_WIDTH-1:0] eng_data_i,
  output logic                 eng_gnt_o,
  output logic                 eng_done_o,
  input  logic                 str_req_i,
  input  logic [TW-1:0]        str_target_i,
  output logic [BUS_WIDTH-1:0] str_data_o,
  output logic                 str_valid_o,
  input  logic                 str_ready_i,
  output logic                 str_busy_o,
  output logic                 str_done_o,
  input  logic                 host_rd_req_i,
  input  logic [TW-1:0]        host_rd_target_i,
  input  logic [AW-1:0]        host_rd_addr_i,
  output logic [BUS_WIDTH-1:0] host_rd_data_o,
  output logic                 host_rd_valid_o,
  output logic                 sp_write_enable_o,
  output logic                 sp_mode_o,
  output logic [AW-1:0]        sp_address_o,
  output logic [TW-1:0]        sp_write_target_o,
  output logic [TW-1:0]        sp_read_target_o,
  output logic [BUS_WIDTH-1:0] sp_data_o,
  input  logic [BUS_WIDTH-1:0] sp_data_i,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  import sp_pkg::*;

  localparam logic [AW:0] CNT_LAST = (AW + 1)'(NELEM - 1);

  state_e               r_state;
  logic [AW:0]          r_addr_cnt;
  logic [TW-1:0]        r_tgt;
  logic                 r_eng_gnt;
  logic                 r_eng_done;
  logic                 r_host_valid;
  logic [BUS_WIDTH-1:0] r_host_data;

  logic w_idle;
  logic w_eng_go;
  logic w_str_go;
  logic w_host_go;
  logic w_str_load;
  logic w_str_last;
  logic w_str_busy;

  assign w_idle   = (r_state == IDLE);
  assign w_eng_go = w_idle && eng_req_i;
  assign w_str_go = w_idle && !eng_req_i && str_req_i;
  // Blocking on the pending valid pulse keeps host_rd_valid_o a true pulse;
  // a request still held afterwards is served on the following cycle.
  assign w_host_go = w_idle && !eng_req_i && !str_req_i && host_rd_req_i &&
                     !r_host_valid;

  sp_stream_out #(
    .BUS_WIDTH (BUS_WIDTH),
    .NELEM     (NELEM),
    .CW        (AW + 1)
  ) u_stream (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_start   (w_str_go),
    .i_rd_data (sp_data_i),
    .i_ready   (str_ready_i),
    .o_data    (str_data_o),
    .o_valid   (str_valid_o),
    .o_busy    (w_str_busy),
    .o_done    (str_done_o),
    .o_load    (w_str_load),
    .o_last    (w_str_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_addr_cnt   <= '0;
      r_tgt        <= '0;
      r_eng_gnt    <= 1'b0;
      r_eng_done   <= 1'b0;
      r_host_valid <= 1'b0;
      r_host_data  <= '0;
    end else begin
      r_eng_done   <= 1'b0;
      r_host_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_eng_go) begin
            r_state    <= WRITE;
            r_tgt      <= eng_target_i;
            r_addr_cnt <= '0;
            r_eng_gnt  <= 1'b1;
          end else if (w_str_go) begin
            r_state    <= STREAM;
            r_tgt      <= str_target_i;
            r_addr_cnt <= '0;
          end else if (w_host_go) begin
            r_host_data  <= sp_data_i;
            r_host_valid <= 1'b1;
          end
        end
        WRITE: begin
          if (eng_valid_i) begin
            r_addr_cnt <= r_addr_cnt + 1'b1;
            if (r_addr_cnt == CNT_LAST) begin
              r_state    <= IDLE;
              r_eng_gnt  <= 1'b0;
              r_eng_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_str_load) r_addr_cnt <= r_addr_cnt + 1'b1;
          if (w_str_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sp_write_enable_o = 1'b0;
    sp_mode_o         = 1'b0;
    sp_address_o      = '0;
    sp_write_target_o = '0;
    sp_read_target_o  = '0;
    sp_data_o         = '0;
    case (r_state)
      WRITE: begin
        sp_write_enable_o = eng_valid_i;
        sp_address_o      = r_addr_cnt[AW-1:0];
        sp_write_target_o = r_tgt;
        sp_data_o         = eng_data_i;
      end
      STREAM: begin
        sp_mode_o        = 1'b1;
        sp_address_o     = r_addr_cnt[AW-1:0];
        sp_read_target_o = r_tgt;
      end
      default: begin
        if (w_host_go) begin
          sp_mode_o        = 1'b1;
          sp_address_o     = host_rd_addr_i;
          sp_read_target_o = host_rd_target_i;
        end
      end
    endcase
  end

  assign eng_gnt_o       = r_eng_gnt;
  assign eng_done_o      = r_eng_done;
  assign str_busy_o      = w_str_busy;
  assign host_rd_data_o  = r_host_data;
  assign host_rd_valid_o = r_host_valid;

`ifdef SP_CTRL_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (eng_valid_i && (r_state != WRITE)) ||
                     (w_eng_go  && (int'(eng_target_i)     >= SP_NTARGETS)) ||
                     (w_str_go  && (int'(str_target_i)     >= SP_NTARGETS)) ||
                     (w_host_go && (int'(host_rd_target_i) >= SP_NTARGETS)) ||
                     (str_ready_i && !w_str_busy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clr_i) r_err <= 1'b0;
  end

  assign err_o = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr_i;
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_sp_access_ctrl.sv
// Directed bench for sp_access_ctrl with a behavioural 4-target x 4-word
// scratchpad (combinational read, clocked write).
module tb_sp_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        eng_req_i, eng_valid_i;
  logic [1:0]  eng_target_i;
  logic [63:0] eng_data_i;
  logic        eng_gnt_o, eng_done_o;
  logic        str_req_i, str_ready_i;
  logic [1:0]  str_target_i;
  logic [63:0] str_data_o;
  logic        str_valid_o, str_busy_o, str_done_o;
  logic        host_rd_req_i;
  logic [1:0]  host_rd_target_i, host_rd_addr_i;
  logic [63:0] host_rd_data_o;
  logic        host_rd_valid_o;
  logic        sp_write_enable_o, sp_mode_o;
  logic [1:0]  sp_address_o, sp_write_target_o, sp_read_target_o;
  logic [63:0] sp_data_o, sp_data_i;
  logic        err_o, err_clr_i;

  logic [63:0] mem [0:3][0:3];
  logic        mem_clr;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_err;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int t = 0; t < 4; t++)
        for (int a = 0; a < 4; a++) mem[t][a] <= '0;
    end else if (sp_write_enable_o) begin
      mem[sp_write_target_o][sp_address_o] <= sp_data_o;
    end
  end

  assign sp_data_i = mem[sp_read_target_o][sp_address_o];

  sp_access_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .eng_req_i         (eng_req_i),
    .eng_target_i      (eng_target_i),
    .eng_valid_i       (eng_valid_i),
    .eng_data_i        (eng_data_i),
    .eng_gnt_o         (eng_gnt_o),
    .eng_done_o        (eng_done_o),
    .str_req_i         (str_req_i),
    .str_target_i      (str_target_i),
    .str_data_o        (str_data_o),
    .str_valid_o       (str_valid_o),
    .str_ready_i       (str_ready_i),
    .str_busy_o        (str_busy_o),
    .str_done_o        (str_done_o),
    .host_rd_req_i     (host_rd_req_i),
    .host_rd_target_i  (host_rd_target_i),
    .host_rd_addr_i    (host_rd_addr_i),
    .host_rd_data_o    (host_rd_data_o),
    .host_rd_valid_o   (host_rd_valid_o),
    .sp_write_enable_o (sp_write_enable_o),
    .sp_mode_o         (sp_mode_o),
    .sp_address_o      (sp_address_o),
    .sp_write_target_o (sp_write_target_o),
    .sp_read_target_o  (sp_read_target_o),
    .sp_data_o         (sp_data_o),
    .sp_data_i         (sp_data_i),
    .err_o             (err_o),
    .err_clr_i         (err_clr_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
`ifdef SP_CTRL_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_ni = 1'b0; mem_clr = 1'b1;
    eng_req_i = 0; eng_valid_i = 0; eng_target_i = 0; eng_data_i = '0;
    str_req_i = 0; str_ready_i = 0; str_target_i = 0;
    host_rd_req_i = 0; host_rd_target_i = 0; host_rd_addr_i = 0;
    err_clr_i = 0;
    step(); step();
    chk("rst_gnt", eng_gnt_o, 0);
    chk("rst_busy", str_busy_o, 0);
    chk("rst_sval", str_valid_o, 0);
    chk("rst_hval", host_rd_valid_o, 0);
    chk("rst_mode", sp_mode_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1; mem_clr = 1'b0;
    step();

    // host read target 0 address 3 after reset
    host_rd_req_i = 1; host_rd_target_i = 0; host_rd_addr_i = 3;
    #1;
    chk("hr_mode", sp_mode_o, 1);
    chk("hr_addr", sp_address_o, 3);
    chk("hr_val_pre", host_rd_valid_o, 0);
    step();
    chk("hr_val", host_rd_valid_o, 1);
    chk("hr_data", host_rd_data_o, 64'h0);
    host_rd_req_i = 0;
    step();
    chk("hr_val_end", host_rd_valid_o, 0);

    // engine burst to target 2
    eng_req_i = 1; eng_target_i = 2;
    step();
    chk("eb_gnt", eng_gnt_o, 1);
    eng_req_i = 0; eng_target_i = 0;
    for (int i = 0; i < 4; i++) begin
      eng_valid_i = 1; eng_data_i = 64'h11 * (i + 1);
      #1;
      chk("eb_we", sp_write_enable_o, 1);
      chk("eb_addr", sp_address_o, i);
      chk("eb_tgt", sp_write_target_o, 2);
      chk("eb_data", sp_data_o, 64'h11 * (i + 1));
      chk("eb_done_early", eng_done_o, 0);
      step();
    end
    eng_valid_i = 0;
    chk("eb_done", eng_done_o, 1);
    chk("eb_gnt_drop", eng_gnt_o, 0);
    step();
    chk("eb_done_end", eng_done_o, 0);

    // stream target 2 with backpressure on word 1
    str_req_i = 1; str_target_i = 2; str_ready_i = 0;
    step();
    chk("st_busy", str_busy_o, 1);
    chk("st_val0", str_valid_o, 0);
    str_req_i = 0; str_target_i = 0;
    step();
    chk("st_w0v", str_valid_o, 1);
    chk("st_w0", str_data_o, 64'h11);
    str_ready_i = 1;
    step();
    chk("st_w1", str_data_o, 64'h22);
    str_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_v", str_valid_o, 1);
      chk("st_hold_d", str_data_o, 64'h22);
    end
    str_ready_i = 1;
    step();
    chk("st_w2", str_data_o, 64'h33);
    step();
    chk("st_w3", str_data_o, 64'h44);
    chk("st_done_early", str_done_o, 0);
    step();
    chk("st_done", str_done_o, 1);
    chk("st_vend", str_valid_o, 0);
    chk("st_bend", str_busy_o, 0);
    str_ready_i = 0;
    step();
    chk("st_done_end", str_done_o, 0);

    // simultaneous requests: engine, then stream, then host
    eng_req_i = 1; eng_target_i = 3;
    str_req_i = 1; str_target_i = 3;
    host_rd_req_i = 1; host_rd_target_i = 2; host_rd_addr_i = 2;
    #1;
    chk("sim_nohost", sp_mode_o, 0);
    step();
    chk("sim_gnt", eng_gnt_o, 1);
    chk("sim_nobusy", str_busy_o, 0);
    eng_req_i = 0;
    for (int i = 0; i < 4; i++) begin
      eng_valid_i = 1; eng_data_i = 64'hA0 + i;
      step();
      chk("sim_hval_w", host_rd_valid_o, 0);
    end
    eng_valid_i = 0;
    chk("sim_edone", eng_done_o, 1);
    step();
    chk("sim_sbusy", str_busy_o, 1);
    str_req_i = 0; str_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sim_sdata", str_data_o, 64'hA0 + i);
      chk("sim_hval_s", host_rd_valid_o, 0);
    end
    step();
    chk("sim_sdone", str_done_o, 1);
    str_ready_i = 0;
    step();
    chk("sim_hval", host_rd_valid_o, 1);
    chk("sim_hdata", host_rd_data_o, 64'h33);
    host_rd_req_i = 0;
    step();
    chk("sim_hval_end", host_rd_valid_o, 0);

    // reset in the middle of a burst
    eng_req_i = 1; eng_target_i = 1;
    step();
    eng_req_i = 0;
    eng_valid_i = 1; eng_data_i = 64'h77; step();
    eng_data_i = 64'h88; step();
    rst_ni = 0;
    #1;
    chk("mr_gnt", eng_gnt_o, 0);
    chk("mr_we", sp_write_enable_o, 0);
    chk("mr_addr", sp_address_o, 0);
    chk("mr_done", eng_done_o, 0);
    step();
    chk("mr_done2", eng_done_o, 0);
    rst_ni = 1; eng_valid_i = 0;
    step();
    chk("mr_done3", eng_done_o, 0);
    chk("mr_err", err_o, 0);
    eng_req_i = 1; eng_target_i = 1;
    step();
    eng_req_i = 0;
    for (int i = 0; i < 4; i++) begin
      eng_valid_i = 1; eng_data_i = 64'h99 + i;
      #1;
      chk("mr_addr_new", sp_address_o, i);
      step();
    end
    eng_valid_i = 0;
    chk("mr_edone", eng_done_o, 1);
    host_rd_req_i = 1; host_rd_target_i = 1; host_rd_addr_i = 0;
    step();
    chk("mr_hdata", host_rd_data_o, 64'h99);
    host_rd_req_i = 0;
    step();

    // error flag: engine valid while idle
    eng_valid_i = 1;
    step();
    eng_valid_i = 0;
    chk("err_set", err_o, exp_err);
    step();
    chk("err_sticky", err_o, exp_err);
    err_clr_i = 1;
    step();
    err_clr_i = 0;
    chk("err_clr", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
